ulpi_phy_responder: RTL and testbench
=====================================

Name: ulpi_phy_responder

Overview:
- PHY-side end of the ULPI link used by the USB CDC core; drives dir/nxt and responds to the link's TX CMDs.
- Implements register write/read, capture of transmitted packets to a byte stream, injection of received packets, and RX CMD reporting of line state.
- Used as a synthesizable loopback/bring-up partner and as the PHY model in core-level benches; runs on the 60 MHz ULPI clock domain.

Parameters:
VENDOR_ID, 16'h0424, returned at register addresses 0x00 (low byte) and 0x01 (high byte)
PRODUCT_ID, 16'h0006, returned at register addresses 0x02 (low byte) and 0x03 (high byte)

Ports:
clk_i  in  1  ULPI 60 MHz clock
rst_i  in  1  reset; synchronous, active-high
ulpi_data_i  in  8  byte driven by the link; meaningful only when ulpi_dir_o=0
ulpi_stp_i  in  1  link stop
ulpi_data_o  out  8  byte driven by the PHY when ulpi_dir_o=1
ulpi_dir_o  out  1  bus direction; 1 = PHY drives
ulpi_nxt_o  out  1  PHY next/throttle
linestate_i  in  2  emulated line state to report
rx_valid_i  in  1  byte stream to inject as a received packet
rx_data_i  in  8  injected byte
rx_last_i  in  1  final byte of injected packet
rx_ready_o  out  1  injected byte consumed this cycle
tx_valid_o  out  1  captured transmit byte valid (1-cycle pulse)
tx_data_o  out  8  captured byte; PID byte is {~pid,pid}
tx_end_o  out  1  pulse on stp ending transmit
tx_abort_o  out  1  with tx_end_o: ulpi_data_i was 8'hFF at stp
func_ctrl_o  out  8  Function Control register
otg_ctrl_o  out  8  OTG Control register

Behaviour:
- All outputs are registered. On reset: state IDLE; dir=0, nxt=0, data_o=0, rx_ready=0, all tx_* =0; func_ctrl=0x41, iface_ctrl=0x00, otg_ctrl=0x06, scratch=0x00; last_ls=linestate_i.
- Transfer rule: a link byte is accepted on an edge where nxt_o=1 and dir_o=0.
- IDLE arbitration, one decision per cycle, checked in this order:
  - rx_valid_i=1 and ulpi_data_i=0 → RX path.
  - Else linestate_i≠last_ls and ulpi_data_i=0 → line-state report.
  - Else ulpi_data_i[7:6]≠00 → decode link command. 8'h00 is idle; 00-prefixed nonzero bytes are ignored.
- Register write (10aaaaaa):
  - nxt=1 on the next cycle (WCMD); address latched on the edge with nxt=1.
  - nxt stays 1 (WDATA); data latched on the following edge, then nxt=0 (WSTP).
  - Write commits on the edge where stp_i=1; return to IDLE.
  - Reset mid-sequence discards the write.
- Register map:
  - 0x00–0x03 ID, read-only.
  - func_ctrl 0x04/05/06 = write/set/clear; bit5 (Reset) is never stored and reads 0.
  - iface 0x07/08/09, otg 0x0A/0B/0C, scratch 0x16/17/18, same write/set/clear pattern.
  - Other addresses: writes ignored, reads return 0x00.
- Register read (11aaaaaa):
  - nxt=1 (RCMD); on the accept edge latch address, nxt=0, dir=1 (turnaround cycle).
  - Next edge: data_o=reg.
  - Next edge: dir=0, data_o=0 (turnaround); IDLE.
- Transmit (01xxpppp):
  - nxt=1 (TCMD); accept edge emits tx_valid with tx_data={~p,p}.
  - nxt held 1 (TDATA); each edge with stp_i=0 emits one tx_valid byte.
  - Edge with stp_i=1: no byte; tx_end=1, tx_abort=(ulpi_data_i==8'hFF), nxt=0; IDLE.
- RX CMD byte = {2'b00, rxevent[1:0], 2'b11, linestate_i}.
- Line-state report:
  - dir=1 (turnaround); next cycle data_o=RX CMD with rxevent=00, nxt=0, last_ls updated.
  - Next cycle dir=0; IDLE.
- RX path:
  - dir=1 (turnaround).
  - Next: RX CMD with rxevent=01, nxt=0.
  - Then per cycle with rx_valid_i=1: data_o=rx_data_i, nxt=1, rx_ready_o=1. If rx_valid_i=0 mid-packet: nxt=0, data_o=RX CMD (rxevent=01).
  - After the byte with rx_last_i: one RX CMD with rxevent=00, then dir=0 turnaround; IDLE.
- ulpi_stp_i outside WSTP/TDATA is ignored. tx_* and rx_ready_o are single-cycle pulses.

Test Plan:
- Write 0x16←0xA5 (TXCMD 0x96, data 0xA5, stp), then read 0x16 (TXCMD 0xD6) → nxt pulses on two accept edges; read returns dir=1, then data_o=0xA5, then dir=0 three cycles after accept.
- Set 0x05←0x20, clear 0x06←0x40 → func_ctrl_o=0x01; read 0x04 returns 0x01; read 0x00..0x03 returns 0x24,0x04,0x06,0x00.
- Transmit TXCMD 0x43, bytes 0x11,0x22, stp with data 0x00 → tx_data sequence 0xC3,0x11,0x22, then tx_end=1, tx_abort=0; repeat ending with stp data 0xFF → tx_abort=1.
- linestate_i 01→10 while bus idle → dir 1 for 2 cycles, data_o=0x0E, nxt=0; no further report while stable.
- Inject 3 bytes 0xD2,0x01,0x02 with rx_valid low for one cycle between bytes 2 and 3 → sequence: turnaround, RX CMD 0x1F-form (rxevent=01), bytes with nxt=1, one nxt=0 RX CMD gap, RX CMD rxevent=00, dir=0.
- Assert rst_i during TDATA and during the RX path → next cycle dir=0, nxt=0, outputs and registers at reset values; pending write not committed.

Source files
------------

// File: rtl/ulpi_phy_responder.sv
// PHY side of a ULPI link: answers register TX CMDs, captures transmit packets,
// injects received packets and reports line-state changes as RX CMDs.
module ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_stp_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_dir_o,
  output logic       ulpi_nxt_o,
  input  logic [1:0] linestate_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_last_i,
  output logic       rx_ready_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       tx_end_o,
  output logic       tx_abort_o,
  output logic [7:0] func_ctrl_o,
  output logic [7:0] otg_ctrl_o
);

  // state   | meaning
  // IDLE    | bus idle, arbitrating rx / line state / link command
  // WCMD    | reg write, nxt=1, address accepted next edge
  // WDATA   | reg write, data accepted next edge
  // WSTP    | reg write, waiting for stp to commit
  // RCMD    | reg read, nxt=1, address accepted next edge
  // RTURN   | reg read, turnaround with dir=1
  // RDATA   | reg read, data on bus
  // TCMD    | transmit, nxt=1, PID accepted next edge
  // TDATA   | transmit, one byte per edge until stp
  // LS_TURN | line-state report turnaround
  // LS_CMD  | line-state RX CMD on bus
  // RX_TURN | rx packet turnaround
  // RX_DATA | rx packet bytes / gap RX CMDs
  // RX_EOP  | end-of-packet RX CMD on bus
  // RX_END  | final turnaround back to link
  typedef enum logic [3:0] {
    IDLE, WCMD, WDATA, WSTP, RCMD, RTURN, RDATA, TCMD, TDATA,
    LS_TURN, LS_CMD, RX_TURN, RX_DATA, RX_EOP, RX_END
  } state_t;

  state_t     state;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [7:0] iface_ctrl;
  logic [7:0] scratch;
  logic [1:0] last_ls;
  logic [7:0] rd_data;

  function automatic logic [7:0] rx_cmd(input logic [1:0] ev, input logic [1:0] ls);
    return {2'b00, ev, 2'b11, ls};
  endfunction

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      6'h00:               rd_data = VENDOR_ID[7:0];
      6'h01:               rd_data = VENDOR_ID[15:8];
      6'h02:               rd_data = PRODUCT_ID[7:0];
      6'h03:               rd_data = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rd_data = func_ctrl_o;
      6'h07, 6'h08, 6'h09: rd_data = iface_ctrl;
      6'h0A, 6'h0B, 6'h0C: rd_data = otg_ctrl_o;
      6'h16, 6'h17, 6'h18: rd_data = scratch;
      default:             rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ulpi_dir_o  <= 1'b0;
      ulpi_nxt_o  <= 1'b0;
      ulpi_data_o <= 8'h00;
      rx_ready_o  <= 1'b0;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      tx_end_o    <= 1'b0;
      tx_abort_o  <= 1'b0;
      func_ctrl_o <= 8'h41;
      iface_ctrl  <= 8'h00;
      otg_ctrl_o  <= 8'h06;
      scratch     <= 8'h00;
      addr        <= 6'h00;
      wdata       <= 8'h00;
      last_ls     <= linestate_i;
    end else begin
      tx_valid_o <= 1'b0;
      tx_end_o   <= 1'b0;
      tx_abort_o <= 1'b0;
      rx_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid_i && ulpi_data_i == 8'h00) begin
            ulpi_dir_o <= 1'b1;
            state      <= RX_TURN;
          end else if (linestate_i != last_ls && ulpi_data_i == 8'h00) begin
            ulpi_dir_o <= 1'b1;
            state      <= LS_TURN;
          end else if (ulpi_data_i[7:6] != 2'b00) begin
            ulpi_nxt_o <= 1'b1;
            case (ulpi_data_i[7:6])
              2'b10:   state <= WCMD;
              2'b11:   state <= RCMD;
              default: state <= TCMD;
            endcase
          end
        end
        WCMD: begin
          addr  <= ulpi_data_i[5:0];
          state <= WDATA;
        end
        WDATA: begin
          wdata      <= ulpi_data_i;
          ulpi_nxt_o <= 1'b0;
          state      <= WSTP;
        end
        WSTP: begin
          if (ulpi_stp_i) begin
            // Reset bit of Function Control is self-clearing, so it is never held.
            case (addr)
              6'h04:   func_ctrl_o <= wdata & 8'hDF;
              6'h05:   func_ctrl_o <= (func_ctrl_o | wdata) & 8'hDF;
              6'h06:   func_ctrl_o <= func_ctrl_o & ~wdata;
              6'h07:   iface_ctrl  <= wdata;
              6'h08:   iface_ctrl  <= iface_ctrl | wdata;
              6'h09:   iface_ctrl  <= iface_ctrl & ~wdata;
              6'h0A:   otg_ctrl_o  <= wdata;
              6'h0B:   otg_ctrl_o  <= otg_ctrl_o | wdata;
              6'h0C:   otg_ctrl_o  <= otg_ctrl_o & ~wdata;
              6'h16:   scratch     <= wdata;
              6'h17:   scratch     <= scratch | wdata;
              6'h18:   scratch     <= scratch & ~wdata;
              default: ;
            endcase
            state <= IDLE;
          end
        end
        RCMD: begin
          addr       <= ulpi_data_i[5:0];
          ulpi_nxt_o <= 1'b0;
          ulpi_dir_o <= 1'b1;
          state      <= RTURN;
        end
        RTURN: begin
          ulpi_data_o <= rd_data;
          state       <= RDATA;
        end
        RDATA: begin
          ulpi_dir_o  <= 1'b0;
          ulpi_data_o <= 8'h00;
          state       <= IDLE;
        end
        TCMD: begin
          tx_valid_o <= 1'b1;
          tx_data_o  <= {~ulpi_data_i[3:0], ulpi_data_i[3:0]};
          state      <= TDATA;
        end
        TDATA: begin
          if (ulpi_stp_i) begin
            tx_end_o   <= 1'b1;
            tx_abort_o <= (ulpi_data_i == 8'hFF);
            ulpi_nxt_o <= 1'b0;
            state      <= IDLE;
          end else begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= ulpi_data_i;
          end
        end
        LS_TURN: begin
          ulpi_data_o <= rx_cmd(2'b00, linestate_i);
          ulpi_nxt_o  <= 1'b0;
          last_ls     <= linestate_i;
          state       <= LS_CMD;
        end
        LS_CMD, RX_END: begin
          ulpi_dir_o  <= 1'b0;
          ulpi_data_o <= 8'h00;
          state       <= IDLE;
        end
        RX_TURN: begin
          ulpi_data_o <= rx_cmd(2'b01, linestate_i);
          ulpi_nxt_o  <= 1'b0;
          state       <= RX_DATA;
        end
        RX_DATA: begin
          if (rx_valid_i) begin
            ulpi_data_o <= rx_data_i;
            ulpi_nxt_o  <= 1'b1;
            rx_ready_o  <= 1'b1;
            if (rx_last_i) state <= RX_EOP;
          end else begin
            ulpi_data_o <= rx_cmd(2'b01, linestate_i);
            ulpi_nxt_o  <= 1'b0;
          end
        end
        RX_EOP: begin
          ulpi_data_o <= rx_cmd(2'b00, linestate_i);
          ulpi_nxt_o  <= 1'b0;
          state       <= RX_END;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Bench for ulpi_phy_responder: plays the ULPI link and packet source, and compares
// the PHY against a register-map / packet reference model.
`timescale 1ns/1ps
module tb_ulpi_phy_responder;
  localparam logic [15:0] VID = 16'h0424;
  localparam logic [15:0] PID = 16'h0006;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       stp = 1'b0;
  logic [1:0] ls = 2'b01;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_last = 1'b0;
  logic [7:0] data_o;
  logic       dir, nxt, rx_ready, tx_valid, tx_end, tx_abort;
  logic [7:0] tx_data, func_ctrl, otg_ctrl;

  ulpi_phy_responder #(.VENDOR_ID(VID), .PRODUCT_ID(PID)) dut (
    .clk_i(clk), .rst_i(rst), .ulpi_data_i(data_i), .ulpi_stp_i(stp),
    .ulpi_data_o(data_o), .ulpi_dir_o(dir), .ulpi_nxt_o(nxt), .linestate_i(ls),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_last_i(rx_last), .rx_ready_o(rx_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_end_o(tx_end), .tx_abort_o(tx_abort),
    .func_ctrl_o(func_ctrl), .otg_ctrl_o(otg_ctrl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: four write/set/clear registers plus read-only ID bytes.
  logic [7:0] m_reg [4];
  int         m_base [4] = '{4, 7, 10, 22};

  task automatic model_reset();
    m_reg[0] = 8'h41; m_reg[1] = 8'h00; m_reg[2] = 8'h06; m_reg[3] = 8'h00;
  endtask

  function automatic int model_group(input int a);
    for (int g = 0; g < 4; g++) if (a >= m_base[g] && a < m_base[g] + 3) return g;
    return -1;
  endfunction

  task automatic model_write(input int a, input logic [7:0] d);
    int g;
    logic [7:0] v;
    g = model_group(a);
    if (g < 0) return;
    case (a - m_base[g])
      0:       v = d;
      1:       v = m_reg[g] | d;
      default: v = m_reg[g] & ~d;
    endcase
    if (g == 0) v[5] = 1'b0;
    m_reg[g] = v;
  endtask

  function automatic logic [7:0] model_read(input int a);
    logic [31:0] ids;
    int g;
    ids = {PID, VID};
    if (a < 4) return ids[8*a +: 8];
    g = model_group(a);
    return (g < 0) ? 8'h00 : m_reg[g];
  endfunction

  // Transmit capture monitor
  logic [7:0] tx_cap [$];
  int         tx_ends = 0;
  logic       tx_last_abort = 1'b0;
  always @(negedge clk) begin
    if (tx_valid) tx_cap.push_back(tx_data);
    if (tx_end) begin
      tx_ends++;
      tx_last_abort = tx_abort;
    end
  end

  logic [7:0] pay [16];
  logic [7:0] rx_pay [8];
  int         rx_gap [8];

  // Link-side drivers; all start and end on a negedge with the PHY idle.
  task automatic link_write(input logic [5:0] a, input logic [7:0] d, output logic [2:0] shape);
    data_i = {2'b10, a};
    @(negedge clk); shape[2] = nxt;
    @(negedge clk); shape[1] = nxt; data_i = d;
    @(negedge clk); shape[0] = nxt; data_i = 8'h00; stp = 1'b1;
    @(negedge clk); stp = 1'b0;
  endtask

  task automatic link_read(input logic [5:0] a, output logic [7:0] rd, output logic [3:0] shape);
    data_i = {2'b11, a};
    @(negedge clk); shape[3] = nxt;
    @(negedge clk); shape[2] = dir & ~nxt; data_i = 8'h00;
    @(negedge clk); shape[1] = dir; rd = data_o;
    @(negedge clk); shape[0] = dir | (data_o != 8'h00);
  endtask

  task automatic link_tx(input logic [3:0] p, input int n, input logic [7:0] endb,
                         output int hi, output logic fin);
    hi = 0;
    data_i = {2'b01, 2'($urandom_range(0, 3)), p};
    @(negedge clk); hi += int'(nxt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); hi += int'(nxt); data_i = pay[i];
    end
    @(negedge clk); hi += int'(nxt); data_i = endb; stp = 1'b1;
    @(negedge clk); fin = nxt; stp = 1'b0; data_i = 8'h00;
  endtask

  task automatic apply_reset();
    rst = 1'b1; data_i = 8'h00; stp = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({dir, nxt, data_o} !== 10'h000) $display("FAIL reset_bus got dir=%b nxt=%b data=%h exp 0 0 00", dir, nxt, data_o); else passes++;
    checks++; if ({rx_ready, tx_valid, tx_end, tx_abort, tx_data} !== 12'h000) $display("FAIL reset_pulses got %b %b %b %b %h exp all 0", rx_ready, tx_valid, tx_end, tx_abort, tx_data); else passes++;
    checks++; if (func_ctrl !== 8'h41) $display("FAIL reset_func got %h exp 41", func_ctrl); else passes++;
    checks++; if (otg_ctrl !== 8'h06) $display("FAIL reset_otg got %h exp 06", otg_ctrl); else passes++;
  endtask

  task automatic test_write_read();
    logic [2:0] ws;
    logic [3:0] rs;
    logic [7:0] rd;
    link_write(6'h16, 8'hA5, ws); model_write(6'h16, 8'hA5);
    checks++; if (ws !== 3'b110) $display("FAIL wr_nxt_shape got %b exp 110", ws); else passes++;
    link_read(6'h16, rd, rs);
    checks++; if (rs !== 4'b1110) $display("FAIL rd_shape got %b exp 1110", rs); else passes++;
    checks++; if (rd !== 8'hA5) $display("FAIL rd_scratch got %h exp a5", rd); else passes++;
  endtask

  task automatic test_func_ids();
    logic [2:0] ws;
    logic [3:0] rs;
    logic [7:0] rd;
    logic [7:0] id_exp [4];
    id_exp = '{8'h24, 8'h04, 8'h06, 8'h00};
    link_write(6'h05, 8'h20, ws); model_write(6'h05, 8'h20);
    link_write(6'h06, 8'h40, ws); model_write(6'h06, 8'h40);
    checks++; if (func_ctrl !== 8'h01) $display("FAIL func_set_clr got %h exp 01", func_ctrl); else passes++;
    link_read(6'h04, rd, rs);
    checks++; if (rd !== 8'h01) $display("FAIL rd_func got %h exp 01", rd); else passes++;
    for (int a = 0; a < 4; a++) begin
      link_read(6'(a), rd, rs);
      checks++; if (rd !== id_exp[a]) $display("FAIL rd_id[%0d] got %h exp %h", a, rd, id_exp[a]); else passes++;
    end
  endtask

  task automatic test_transmit(input logic [3:0] p, input int n, input logic [7:0] endb);
    int hi;
    logic fin;
    logic [7:0] exp [$];
    exp.delete();
    exp.push_back(8'((15 - int'(p)) * 16 + int'(p)));
    for (int i = 0; i < n; i++) exp.push_back(pay[i]);
    tx_cap.delete(); tx_ends = 0;
    link_tx(p, n, endb, hi, fin);
    @(negedge clk);
    checks++; if (hi !== n + 2) $display("FAIL tx_nxt_cycles got %0d exp %0d", hi, n + 2); else passes++;
    checks++; if (fin !== 1'b0) $display("FAIL tx_nxt_drop got %b exp 0", fin); else passes++;
    checks++; if (tx_cap.size() !== exp.size()) $display("FAIL tx_count got %0d exp %0d", tx_cap.size(), exp.size()); else passes++;
    for (int i = 0; i < exp.size() && i < tx_cap.size(); i++) begin
      checks++; if (tx_cap[i] !== exp[i]) $display("FAIL tx_byte[%0d] got %h exp %h", i, tx_cap[i], exp[i]); else passes++;
    end
    checks++; if (tx_ends !== 1) $display("FAIL tx_end_count got %0d exp 1", tx_ends); else passes++;
    checks++; if (tx_last_abort !== (endb == 8'hFF)) $display("FAIL tx_abort got %b exp %b", tx_last_abort, endb == 8'hFF); else passes++;
  endtask

  task automatic test_linestate(input logic [1:0] nls);
    int dir_hi;
    logic [7:0] exp;
    exp = 8'(8'h0C + {6'd0, nls});
    ls = nls;
    @(negedge clk);
    checks++; if ({dir, nxt} !== 2'b10) $display("FAIL ls_turn got dir=%b nxt=%b exp 1 0", dir, nxt); else passes++;
    @(negedge clk);
    checks++; if ({dir, nxt, data_o} !== {2'b10, exp}) $display("FAIL ls_cmd got dir=%b nxt=%b data=%h exp 1 0 %h", dir, nxt, data_o, exp); else passes++;
    @(negedge clk);
    checks++; if (dir !== 1'b0) $display("FAIL ls_release got dir=%b exp 0", dir); else passes++;
    dir_hi = 0;
    repeat (4) begin @(negedge clk); dir_hi += int'(dir); end
    checks++; if (dir_hi !== 0) $display("FAIL ls_stable got %0d dir cycles exp 0", dir_hi); else passes++;
  endtask

  task automatic test_rx(input int n);
    logic [7:0] c01, c00;
    c01 = 8'(8'h1C + {6'd0, ls});
    c00 = 8'(8'h0C + {6'd0, ls});
    rx_valid = 1'b1; rx_data = rx_pay[0]; rx_last = (n == 1);
    @(negedge clk);
    checks++; if ({dir, nxt, rx_ready} !== 3'b100) $display("FAIL rx_turn got dir=%b nxt=%b rdy=%b exp 1 0 0", dir, nxt, rx_ready); else passes++;
    @(negedge clk);
    checks++; if ({dir, nxt, data_o} !== {2'b10, c01}) $display("FAIL rx_cmd_start got %b %b %h exp 1 0 %h", dir, nxt, data_o, c01); else passes++;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < ((i == 0) ? 0 : rx_gap[i]); g++) begin
        rx_valid = 1'b0;
        @(negedge clk);
        checks++; if ({dir, nxt, rx_ready, data_o} !== {3'b100, c01}) $display("FAIL rx_gap[%0d] got %b %b %b %h exp 1 0 0 %h", i, dir, nxt, rx_ready, data_o, c01); else passes++;
      end
      rx_valid = 1'b1; rx_data = rx_pay[i]; rx_last = (i == n - 1);
      @(negedge clk);
      checks++; if ({dir, nxt, rx_ready, data_o} !== {3'b111, rx_pay[i]}) $display("FAIL rx_byte[%0d] got %b %b %b %h exp 1 1 1 %h", i, dir, nxt, rx_ready, data_o, rx_pay[i]); else passes++;
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    @(negedge clk);
    checks++; if ({dir, nxt, rx_ready, data_o} !== {3'b100, c00}) $display("FAIL rx_eop got %b %b %b %h exp 1 0 0 %h", dir, nxt, rx_ready, data_o, c00); else passes++;
    @(negedge clk);
    checks++; if ({dir, data_o} !== 9'h000) $display("FAIL rx_release got dir=%b data=%h exp 0 00", dir, data_o); else passes++;
  endtask

  task automatic test_random_regs();
    logic [5:0] pool [12];
    logic [5:0] a;
    logic [7:0] d, rd;
    logic [2:0] ws;
    logic [3:0] rs;
    pool = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h16, 6'h17, 6'h18};
    repeat (24) begin
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : pool[$urandom_range(0, 11)];
      d = 8'($urandom);
      link_write(a, d, ws);
      model_write(int'(a), d);
      checks++; if (ws !== 3'b110) $display("FAIL rnd_wr_shape addr=%h got %b exp 110", a, ws); else passes++;
      checks++; if ({func_ctrl, otg_ctrl} !== {m_reg[0], m_reg[2]}) $display("FAIL rnd_outputs addr=%h got %h %h exp %h %h", a, func_ctrl, otg_ctrl, m_reg[0], m_reg[2]); else passes++;
    end
    for (int i = 0; i < 32; i++) begin
      link_read(6'(i), rd, rs);
      checks++; if ({rs, rd} !== {4'b1110, model_read(i)}) $display("FAIL rnd_read addr=%h got shape=%b data=%h exp 1110 %h", i, rs, rd, model_read(i)); else passes++;
    end
  endtask

  task automatic test_reset_midway();
    logic [2:0] ws;
    logic [3:0] rs;
    logic [7:0] rd;
    link_write(6'h0A, 8'h00, ws);
    link_write(6'h04, 8'h00, ws);
    data_i = {2'b10, 6'h16};
    @(negedge clk);
    @(negedge clk); data_i = 8'h5A;
    @(negedge clk); data_i = 8'h00; rst = 1'b1;
    @(negedge clk); rst = 1'b0; model_reset();
    checks++; if ({dir, nxt, func_ctrl, otg_ctrl} !== {2'b00, 8'h41, 8'h06}) $display("FAIL rst_wr got %b %b %h %h exp 0 0 41 06", dir, nxt, func_ctrl, otg_ctrl); else passes++;
    stp = 1'b1;
    @(negedge clk); stp = 1'b0;
    link_read(6'h16, rd, rs);
    checks++; if (rd !== 8'h00) $display("FAIL rst_wr_discard got %h exp 00", rd); else passes++;

    data_i = {2'b01, 2'b00, 4'h5};
    @(negedge clk);
    @(negedge clk); data_i = 8'h33; rst = 1'b1;
    @(negedge clk); rst = 1'b0; data_i = 8'h00;
    checks++; if ({dir, nxt, tx_valid, tx_end, tx_abort, func_ctrl} !== {5'b00000, 8'h41}) $display("FAIL rst_tdata got %b %b %b %b %b %h exp 0 0 0 0 0 41", dir, nxt, tx_valid, tx_end, tx_abort, func_ctrl); else passes++;

    rx_valid = 1'b1; rx_data = 8'h77; rx_last = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; rx_valid = 1'b0;
    checks++; if ({dir, nxt, rx_ready, data_o, otg_ctrl} !== {3'b000, 8'h00, 8'h06}) $display("FAIL rst_rx got %b %b %b %h %h exp 0 0 0 00 06", dir, nxt, rx_ready, data_o, otg_ctrl); else passes++;
    @(negedge clk);
    tx_cap.delete();
  endtask

  initial begin
    int n;
    logic [1:0] nls;
    test_reset();
    test_write_read();
    test_func_ids();

    pay[0] = 8'h11; pay[1] = 8'h22;
    test_transmit(4'h3, 2, 8'h00);
    test_transmit(4'h3, 2, 8'hFF);
    repeat (4) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      test_transmit(4'($urandom_range(0, 15)), n, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 254)));
    end

    test_linestate(2'b10);
    repeat (3) begin
      nls = ls ^ 2'($urandom_range(1, 3));
      test_linestate(nls);
    end

    rx_pay[0] = 8'hD2; rx_pay[1] = 8'h01; rx_pay[2] = 8'h02;
    rx_gap[0] = 0; rx_gap[1] = 0; rx_gap[2] = 1;
    test_rx(3);
    repeat (4) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        rx_pay[i] = 8'($urandom);
        rx_gap[i] = $urandom_range(0, 2);
      end
      test_rx(n);
    end

    test_random_regs();
    test_reset_midway();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed so far", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
